// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

  // Per-state control word; the last three bits qualify pcen/ir_write.
  typedef struct packed {
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_src;
    logic             pc_jump;
    logic             pc_branch;
    logic             fetch;
  } ctl_t;

  // R-type functs this controller can execute.
  function automatic logic funct_ok(input logic [FUNCT_W-1:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction

  // Moore control word for a state; anything unlisted stays 0 / add.
  function automatic ctl_t state_ctl(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.pc_src = PC_ALU; c.fetch = 1'b1; end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_RTEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BEQ:    begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_SUB; c.pc_src = PC_ALUOUT; c.pc_branch = 1'b1; end
      S_JUMP:   begin c.pc_src = PC_JUMP; c.pc_jump = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps (alu_op, funct) to the 3-bit ALU operation code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]   i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [ALUC_W-1:0]  o_alu_ctrl_c
);

  // Fixed add/sub for address and branch work, funct lookup for R-type.
  always_comb begin
    o_alu_ctrl_c = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_ctrl_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_SUB:   o_alu_ctrl_c = ALU_SUB;
          F_AND:   o_alu_ctrl_c = ALU_AND;
          F_OR:    o_alu_ctrl_c = ALU_OR;
          F_SLT:   o_alu_ctrl_c = ALU_SLT;
          default: o_alu_ctrl_c = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Control word is registered from the next
// state; only the mem_ready/zero qualified enables are combinational.
// Optional performance counters: define MIPS_CTRL_PERFCNT_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
`ifdef MIPS_CTRL_PERFCNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [SEL_W-1:0]     alu_src_b,
  output logic [ALUC_W-1:0]    alu_ctrl,
  output logic [SEL_W-1:0]     pc_src,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state_o
`ifdef MIPS_CTRL_PERFCNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt
`endif
);

  localparam ctl_t CTL_FETCH = state_ctl(S_FETCH);

  state_e              r_state;
  state_e              w_state_nxt;
  ctl_t                r_ctl;
  ctl_t                w_ctl_nxt;
  logic [ALUC_W-1:0]   r_alu_ctrl;
  logic [ALUC_W-1:0]   w_alu_ctrl_nxt;
  logic                r_illegal;
  logic                w_run;

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_state_nxt = funct_ok(funct) ? S_RTEXEC : S_TRAP;
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_ADDI:      w_state_nxt = S_ADDIEX;
          OP_BEQ:       w_state_nxt = S_BEQ;
          OP_J:         w_state_nxt = S_JUMP;
          default:      w_state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: w_state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_state_nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_state_nxt = S_FETCH;
      S_RTEXEC: w_state_nxt = S_ALUWB;
      S_ADDIEX: w_state_nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: w_state_nxt = S_FETCH;
      S_TRAP:   w_state_nxt = S_TRAP;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  assign w_ctl_nxt = state_ctl(w_state_nxt);

  mips_alu_decoder u_alu_dec (
    .i_alu_op     (w_ctl_nxt.alu_op),
    .i_funct      (funct),
    .o_alu_ctrl_c (w_alu_ctrl_nxt)
  );

  // State, registered control word and sticky illegal flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_ctl      <= CTL_FETCH;
      r_alu_ctrl <= ALU_ADD;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctl      <= w_ctl_nxt;
      r_alu_ctrl <= w_alu_ctrl_nxt;
      r_illegal  <= r_illegal | (w_state_nxt == S_TRAP);
    end
  end

  // Everything is held quiet while reset is asserted.
  assign w_run      = reset;
  assign iord       = w_run & r_ctl.iord;
  assign mem_read   = w_run & r_ctl.mem_read;
  assign mem_write  = w_run & r_ctl.mem_write;
  assign reg_dst    = w_run & r_ctl.reg_dst;
  assign mem_to_reg = w_run & r_ctl.mem_to_reg;
  assign reg_write  = w_run & r_ctl.reg_write;
  assign alu_src_a  = w_run & r_ctl.alu_src_a;
  assign alu_src_b  = w_run ? r_ctl.alu_src_b : SRCB_B;
  assign pc_src     = w_run ? r_ctl.pc_src : PC_ALU;
  assign alu_ctrl   = r_alu_ctrl;
  assign ir_write   = w_run & r_ctl.fetch & mem_ready;
  assign pcen       = w_run & (r_ctl.pc_jump | (r_ctl.fetch & mem_ready) | (r_ctl.pc_branch & zero));
  assign illegal    = r_illegal;
  assign state_o    = STATE_W'(r_state);

`ifdef MIPS_CTRL_PERFCNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  assign w_retire = (r_state inside {S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP}) |
                    ((r_state == S_MEMWR) & mem_ready);

  // Free-running cycle and retired-instruction counters, frozen in TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)          r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control unit that sequences the shared `mips` datapath: one ALU, one unified instruction/data memory port, and the register file.
- Moore FSM decodes op/funct from the instruction register and drives every mux select and write enable.
- Memory accesses stall on a `mem_ready` handshake.
- Supported instructions: add, sub, and, or, slt, addi, lw, sw, beq, j.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pcen  out  1  PC register write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register-file write address: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_ctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  sticky unsupported-instruction flag.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, illegal=0. All enables (pcen, mem_read, mem_write, ir_write, reg_write) are forced 0 while reset is low. Mux selects are 0; alu_ctrl=010. Reset mid-instruction abandons the instruction with no partial writes.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - ir_write=1 and pcen=1 only in the cycle mem_ready=1; that cycle also moves to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by op:
  - 000000 -> RTEXEC, or TRAP if funct is not in {100000, 100010, 100100, 100101, 101010}.
  - 100011 or 101011 -> MEMADR.
  - 001000 -> ADDIEX.
  - 000100 -> BEQ.
  - 000010 -> JUMP.
  - any other op -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct, then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pcen=zero (combinational), then FETCH.
- JUMP: pc_src=10, pcen=1, then FETCH.
- TRAP: illegal=1 (sticky), all enables 0. Absorbing state; exit only via reset.
- Outputs not listed for a state are 0; alu_ctrl defaults to add.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles. Each memory stall cycle adds 1.
- mem_read and mem_write are never asserted in the same cycle.

Optional Feature:
- Macro: MIPS_CTRL_PERFCNT_EN.
- With the macro, add outputs:
  - cycle_cnt[CNT_W-1:0]: increments every cycle out of reset except in TRAP.
  - retire_cnt[CNT_W-1:0]: increments on each completed instruction, i.e. the cycle leaving MEMWB, MEMWR (with mem_ready), ALUWB, ADDIWB, BEQ or JUMP.
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
- Without the macro, the ports and registers do not exist.

Decomposition:
- Package mips_ctrl_pkg: state encodings, opcode constants (R, LW, SW, ADDI, BEQ, J), funct constants, ALU control codes, alu_src_b and pc_src select codes.
- Sub-module mips_alu_decoder: combinational map of (alu_op[1:0], funct) to alu_ctrl[2:0], instantiated once in the controller.

Test Plan:
- Instr 00881820 (add), mem_ready=1 -> FETCH, DECODE, RTEXEC (alu_ctrl=010), ALUWB (reg_write=1, reg_dst=1), back to FETCH after 4 cycles. Repeat with 00881824 -> alu_ctrl=000.
- Instr 8CE20000 (lw), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1, mem_read=1; then MEMWB with mem_to_reg=1, reg_write=1. Total 7 cycles.
- Instr ACE40000 (sw) -> MEMWR with mem_write=1, iord=1; reg_write never asserted; 4 cycles.
- Instr 10000001 (beq) with zero=1, then zero=0 -> pcen=1 with pc_src=01 in BEQ; then pcen=0. Each 3 cycles.
- Instr 2025003F (addi), then 08000000 (j) -> ADDIEX alu_src_b=10, ADDIWB reg_dst=0 reg_write=1; JUMP pc_src=10 pcen=1.
- Instr FC000000, and R-type funct 000000 -> TRAP, illegal=1 held with all enables 0. reset=0 mid-lw in MEMRD -> immediate FETCH, illegal cleared, no reg_write.
